// File: rtl/bp_axil_mmio_mailbox.sv
// bp_axil_mmio_mailbox: AXI4-Lite MMIO mailbox between the BP MMIO
// serializer and the host; request words out to host, responses back in.
module bp_axil_mmio_mailbox #(
   parameter int S_AXIL_ADDR_WIDTH = 64,
   parameter int S_AXIL_DATA_WIDTH = 32,
   parameter int req_els_p         = 64,
   parameter int resp_els_p        = 16
) (
   input  logic                           s_axil_aclk,
   input  logic                           s_axil_aresetn,
   input  logic [S_AXIL_ADDR_WIDTH-1:0]   s_axil_awaddr,
   input  logic                           s_axil_awvalid,
   output logic                           s_axil_awready,
   input  logic [2:0]                     s_axil_awprot,
   input  logic [S_AXIL_DATA_WIDTH-1:0]   s_axil_wdata,
   input  logic                           s_axil_wvalid,
   output logic                           s_axil_wready,
   input  logic [S_AXIL_DATA_WIDTH/8-1:0] s_axil_wstrb,
   output logic [1:0]                     s_axil_bresp,
   output logic                           s_axil_bvalid,
   input  logic                           s_axil_bready,
   input  logic [S_AXIL_ADDR_WIDTH-1:0]   s_axil_araddr,
   input  logic                           s_axil_arvalid,
   output logic                           s_axil_arready,
   input  logic [2:0]                     s_axil_arprot,
   output logic [S_AXIL_DATA_WIDTH-1:0]   s_axil_rdata,
   output logic [1:0]                     s_axil_rresp,
   output logic                           s_axil_rvalid,
   input  logic                           s_axil_rready,
   input  logic                           req_v_i,
   input  logic [31:0]                    req_data_i,
   output logic                           req_ready_and_o,
   output logic                           resp_v_o,
   output logic [31:0]                    resp_data_o,
   input  logic                           resp_yumi_i
);

   localparam int DW      = S_AXIL_DATA_WIDTH;
   localparam int SW      = S_AXIL_DATA_WIDTH / 8;
   localparam int REQ_PW  = $clog2(req_els_p);
   localparam int REQ_CW  = $clog2(req_els_p + 1);
   localparam int RESP_PW = $clog2(resp_els_p);
   localparam int RESP_CW = $clog2(resp_els_p + 1);

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   typedef enum logic [1:0] {
      W_IDLE,
      W_ADDR,
      W_DATA,
      W_RESP
   } w_state_e;

   typedef enum logic {
      R_IDLE,
      R_RESP
   } r_state_e;

   w_state_e w_state;
   r_state_e r_state;

   logic unused;
   assign unused = ^{s_axil_awprot, s_axil_arprot,
                     s_axil_awaddr[S_AXIL_ADDR_WIDTH-1:12],
                     s_axil_araddr[S_AXIL_ADDR_WIDTH-1:12]};

   // ---------------- request FIFO state ----------------
   logic [31:0]       req_mem [req_els_p];
   logic [REQ_PW-1:0] req_wptr, req_rptr;
   logic [REQ_CW-1:0] req_cnt, req_cnt_nxt;
   logic              req_rdy_q;
   logic              req_push, req_pop;

   // ---------------- response FIFO state ----------------
   logic [31:0]        resp_mem [resp_els_p];
   logic [RESP_PW-1:0] resp_wptr, resp_rptr;
   logic [RESP_CW-1:0] resp_cnt, resp_cnt_nxt;
   logic               resp_v_q;
   logic               resp_push, resp_pop, resp_full;

   // ---------------- write path ----------------
   logic [11:0]   w_addr_q, w_addr_eff;
   logic [DW-1:0] w_data_q, w_data_eff;
   logic [SW-1:0] w_strb_q, w_strb_eff;
   logic          aw_hs, w_hs, w_fire;
   logic          w_is_resp, w_full_strb;
   logic [1:0]    w_bresp_nxt;

   // ---------------- read path ----------------
   logic [11:0]   ar_addr;
   logic          ar_hs;
   logic [DW-1:0] r_rdata_nxt;
   logic [1:0]    r_rresp_nxt;

   function automatic logic [REQ_PW-1:0] req_inc(input logic [REQ_PW-1:0] p);
      return (p == REQ_PW'(req_els_p - 1)) ? '0 : p + REQ_PW'(1);
   endfunction

   function automatic logic [RESP_PW-1:0] resp_inc(input logic [RESP_PW-1:0] p);
      return (p == RESP_PW'(resp_els_p - 1)) ? '0 : p + RESP_PW'(1);
   endfunction

   assign aw_hs = s_axil_awvalid & s_axil_awready;
   assign w_hs  = s_axil_wvalid & s_axil_wready;
   assign ar_hs = s_axil_arvalid & s_axil_arready;

   assign req_ready_and_o = req_rdy_q;
   assign resp_v_o        = resp_v_q;
   assign resp_data_o     = resp_v_q ? resp_mem[resp_rptr] : '0;

   // Merge latched and live channel fields; flag the cycle entering W_RESP
   always_comb begin
      w_fire     = 1'b0;
      w_addr_eff = w_addr_q;
      w_data_eff = w_data_q;
      w_strb_eff = w_strb_q;
      case (w_state)
         W_IDLE: begin
            w_fire     = aw_hs & w_hs;
            w_addr_eff = s_axil_awaddr[11:0];
            w_data_eff = s_axil_wdata;
            w_strb_eff = s_axil_wstrb;
         end
         W_ADDR: begin
            w_fire     = w_hs;
            w_data_eff = s_axil_wdata;
            w_strb_eff = s_axil_wstrb;
         end
         W_DATA: begin
            w_fire     = aw_hs;
            w_addr_eff = s_axil_awaddr[11:0];
         end
         default: ;
      endcase
   end

   // Decide the write outcome; full is judged on registered occupancy
   always_comb begin
      w_is_resp   = (w_addr_eff == 12'h004);
      w_full_strb = (w_strb_eff == {SW{1'b1}});
      resp_full   = (resp_cnt == RESP_CW'(resp_els_p));
      resp_push   = w_fire & w_is_resp & w_full_strb & ~resp_full;
      if (!w_is_resp)
         w_bresp_nxt = DECERR;
      else if (w_full_strb && !resp_full)
         w_bresp_nxt = OKAY;
      else
         w_bresp_nxt = SLVERR;
   end

   // Write channel FSM with registered ready/valid/resp outputs
   always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
      if (!s_axil_aresetn) begin
         w_state        <= W_IDLE;
         s_axil_awready <= 1'b0;
         s_axil_wready  <= 1'b0;
         s_axil_bvalid  <= 1'b0;
         s_axil_bresp   <= OKAY;
         w_addr_q       <= '0;
         w_data_q       <= '0;
         w_strb_q       <= '0;
      end else if (w_fire) begin
         w_state        <= W_RESP;
         s_axil_awready <= 1'b0;
         s_axil_wready  <= 1'b0;
         s_axil_bvalid  <= 1'b1;
         s_axil_bresp   <= w_bresp_nxt;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (aw_hs) begin
                  w_state        <= W_ADDR;
                  w_addr_q       <= s_axil_awaddr[11:0];
                  s_axil_awready <= 1'b0;
                  s_axil_wready  <= 1'b1;
               end else if (w_hs) begin
                  w_state        <= W_DATA;
                  w_data_q       <= s_axil_wdata;
                  w_strb_q       <= s_axil_wstrb;
                  s_axil_awready <= 1'b1;
                  s_axil_wready  <= 1'b0;
               end else begin
                  s_axil_awready <= 1'b1;
                  s_axil_wready  <= 1'b1;
               end
            end
            W_RESP: begin
               if (s_axil_bready) begin
                  w_state        <= W_IDLE;
                  s_axil_bvalid  <= 1'b0;
                  s_axil_awready <= 1'b1;
                  s_axil_wready  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Read decode at AR acceptance; a 0xC read pops the request head
   always_comb begin
      ar_addr     = s_axil_araddr[11:0];
      r_rdata_nxt = '0;
      r_rresp_nxt = DECERR;
      req_pop     = 1'b0;
      unique case (1'b1)
         (ar_addr == 12'h008): begin
            r_rdata_nxt = DW'(req_cnt);
            r_rresp_nxt = OKAY;
         end
         (ar_addr == 12'h00C): begin
            if (req_cnt != '0) begin
               r_rdata_nxt = req_mem[req_rptr];
               r_rresp_nxt = OKAY;
               req_pop     = ar_hs;
            end else begin
               r_rresp_nxt = SLVERR;
            end
         end
         (ar_addr == 12'h004): begin
            r_rdata_nxt = DW'(resp_cnt);
            r_rresp_nxt = OKAY;
         end
         default: ;
      endcase
   end

   // Read channel FSM; data and resp held until rready
   always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
      if (!s_axil_aresetn) begin
         r_state        <= R_IDLE;
         s_axil_arready <= 1'b0;
         s_axil_rvalid  <= 1'b0;
         s_axil_rdata   <= '0;
         s_axil_rresp   <= OKAY;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ar_hs) begin
                  r_state        <= R_RESP;
                  s_axil_arready <= 1'b0;
                  s_axil_rvalid  <= 1'b1;
                  s_axil_rdata   <= r_rdata_nxt;
                  s_axil_rresp   <= r_rresp_nxt;
               end else begin
                  s_axil_arready <= 1'b1;
               end
            end
            R_RESP: begin
               if (s_axil_rready) begin
                  r_state        <= R_IDLE;
                  s_axil_rvalid  <= 1'b0;
                  s_axil_arready <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign req_push = req_v_i & req_rdy_q;

   always_comb begin
      case ({req_push, req_pop})
         2'b10:   req_cnt_nxt = req_cnt + REQ_CW'(1);
         2'b01:   req_cnt_nxt = req_cnt - REQ_CW'(1);
         default: req_cnt_nxt = req_cnt;
      endcase
   end

   // Request FIFO pointers/count; ready follows registered fullness only
   always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
      if (!s_axil_aresetn) begin
         req_wptr  <= '0;
         req_rptr  <= '0;
         req_cnt   <= '0;
         req_rdy_q <= 1'b0;
      end else begin
         if (req_push) req_wptr <= req_inc(req_wptr);
         if (req_pop)  req_rptr <= req_inc(req_rptr);
         req_cnt   <= req_cnt_nxt;
         req_rdy_q <= (req_cnt_nxt != REQ_CW'(req_els_p));
      end
   end

   // Request FIFO storage
   always_ff @(posedge s_axil_aclk) begin
      if (req_push) req_mem[req_wptr] <= req_data_i;
   end

   assign resp_pop = resp_yumi_i & resp_v_q;

   always_comb begin
      case ({resp_push, resp_pop})
         2'b10:   resp_cnt_nxt = resp_cnt + RESP_CW'(1);
         2'b01:   resp_cnt_nxt = resp_cnt - RESP_CW'(1);
         default: resp_cnt_nxt = resp_cnt;
      endcase
   end

   // Response FIFO pointers/count; AXI push and BP yumi may coincide
   always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
      if (!s_axil_aresetn) begin
         resp_wptr <= '0;
         resp_rptr <= '0;
         resp_cnt  <= '0;
         resp_v_q  <= 1'b0;
      end else begin
         if (resp_push) resp_wptr <= resp_inc(resp_wptr);
         if (resp_pop)  resp_rptr <= resp_inc(resp_rptr);
         resp_cnt <= resp_cnt_nxt;
         resp_v_q <= (resp_cnt_nxt != '0);
      end
   end

   // Response FIFO storage
   always_ff @(posedge s_axil_aclk) begin
      if (resp_push) resp_mem[resp_wptr] <= 32'(w_data_eff);
   end

endmodule
